// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the SPI instruction fetch unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DONE
    } fetch_state_t;

    localparam logic [7:0]  SPI_READ_CMD_DEFAULT = 8'h03;
    localparam int unsigned INSTR_W              = 16;
    localparam int unsigned FRAME_W              = 48;

    // Halfword-aligned byte address, wrapping modulo 2^24.
    function automatic logic [23:0] fetch_byte_addr(input logic [23:0] base,
                                                    input logic [15:0] addr);
        return base + {8'h00, addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 frame shifter: half-rate sck, 48-bit MOSI frame out, MISO shifted in.
module spi_shift_engine
    import cpu_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               spi_miso_in,
    output logic               spi_sck_out,
    output logic               spi_mosi_out,
    output logic [INSTR_W-1:0] rx_data_out,
    output logic               done_out
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);

    logic               active_q, active_d;
    logic               sck_q, sck_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
    logic [INSTR_W-1:0] rx_sr_q, rx_sr_d;

    // Done is the falling-edge slot of the final bit's high phase.
    assign done_out     = active_q && sck_q && (bit_cnt_q == LAST_BIT);
    assign spi_sck_out  = sck_q;
    assign spi_mosi_out = tx_sr_q[FRAME_W-1];
    assign rx_data_out  = rx_sr_q;

    always_comb begin
        active_d  = active_q;
        sck_d     = sck_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        if (abort_in) begin
            active_d  = 1'b0;
            sck_d     = 1'b0;
            bit_cnt_d = '0;
            tx_sr_d   = '0;
        end else if (start_in) begin
            active_d  = 1'b1;
            sck_d     = 1'b0;
            bit_cnt_d = '0;
            tx_sr_d   = frame_in;
        end else if (active_q) begin
            if (!sck_q) begin
                sck_d   = 1'b1;
                rx_sr_d = {rx_sr_q[INSTR_W-2:0], spi_miso_in};
            end else begin
                sck_d = 1'b0;
                if (bit_cnt_q == LAST_BIT) begin
                    active_d  = 1'b0;
                    bit_cnt_d = '0;
                    tx_sr_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    tx_sr_d   = {tx_sr_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            active_q  <= 1'b0;
            sck_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
        end else begin
            active_q  <= active_d;
            sck_q     <= sck_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
        end
    end

endmodule

// File: rtl/instr_fetch_spi.sv
// Instruction fetch unit: reads one 16-bit big-endian instruction per request over SPI.
module instr_fetch_spi
    import cpu_pkg::*;
#(
    parameter logic [7:0]  SPI_CMD_READ = SPI_READ_CMD_DEFAULT,
    parameter logic [23:0] BASE_ADDR    = 24'h000000
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [15:0]        fetch_addr_in,
    input  logic               fetch_req_in,
    input  logic               flush_in,
    output logic               fetch_ready_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid_out,
    output logic               spi_cs_n_out,
    output logic               spi_sck_out,
    output logic               spi_mosi_out,
    input  logic               spi_miso_in
);

    fetch_state_t       state_q, state_d;
    logic [23:0]        addr_q, addr_d;
    logic               cs_n_q, cs_n_d;
    logic               ready_q, ready_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic               eng_start, eng_abort, eng_done;
    logic [INSTR_W-1:0] eng_rx;

    spi_shift_engine u_engine (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .start_in     (eng_start),
        .abort_in     (eng_abort),
        .frame_in     ({SPI_CMD_READ, addr_q, 16'h0000}),
        .spi_miso_in  (spi_miso_in),
        .spi_sck_out  (spi_sck_out),
        .spi_mosi_out (spi_mosi_out),
        .rx_data_out  (eng_rx),
        .done_out     (eng_done)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cs_n_d    = cs_n_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        eng_start = 1'b0;
        eng_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_req_in && !flush_in) begin
                    addr_d  = fetch_byte_addr(BASE_ADDR, fetch_addr_in);
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            CS_SETUP: begin
                if (flush_in) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                end else begin
                    state_d   = SHIFT;
                    eng_start = 1'b1;
                end
            end
            SHIFT: begin
                if (flush_in) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    eng_abort = 1'b1;
                end else if (eng_done) begin
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                    instr_d = eng_rx;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign fetch_ready_out = ready_q;
    assign instr_out       = instr_q;
    assign instr_valid_out = valid_q;
    assign spi_cs_n_out    = cs_n_q;

endmodule

// File: tb/tb_instr_fetch_spi.sv
// Scoreboard bench: two fetch units (base 0 and base 0xFFFFFE) against SPI memory models.
module tb_instr_fetch_spi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] fetch_addr = 16'h0000;

    logic        cs_n_w  [2];
    logic        sck_w   [2];
    logic        mosi_w  [2];
    logic        ready_w [2];
    logic        valid_w [2];
    logic [15:0] instr_w [2];

    logic [7:0]  mem [2][65536];
    logic [31:0] exp_hdr_q   [2][$];
    logic [15:0] exp_instr_q [2][$];
    int unsigned exp_cyc_q   [2][$];
    logic [15:0] last_instr  [2];

    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, g, act, expv);
        end
    endtask

    function automatic logic [23:0] base_of(input int g);
        return (g == 0) ? 24'h000000 : 24'hFFFFFE;
    endfunction

    // Byte address the memory should see: base plus even address, modulo 2^24.
    function automatic logic [23:0] model_addr(input int g, input logic [15:0] a);
        int unsigned s;
        s = int'(base_of(g)) + (int'(a) / 2) * 2;
        s = s % 32'h0100_0000;
        return s[23:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic        miso = 1'b0;
        int unsigned bitcnt = 0;
        int unsigned last_rises = 0;
        logic [31:0] hdr = '0;
        logic [15:0] rdata = '0;
        logic [15:0] a, a1;
        int unsigned hi_cnt = 0;
        bit          prev_cs = 1'b1;
        bit          seen_frame = 1'b0;

        instr_fetch_spi #(
            .SPI_CMD_READ (8'h03),
            .BASE_ADDR    (g == 0 ? 24'h000000 : 24'hFFFFFE)
        ) u_dut (
            .clk_in          (clk),
            .reset_in        (reset),
            .fetch_addr_in   (fetch_addr),
            .fetch_req_in    (fetch_req),
            .flush_in        (flush),
            .fetch_ready_out (ready_w[g]),
            .instr_out       (instr_w[g]),
            .instr_valid_out (valid_w[g]),
            .spi_cs_n_out    (cs_n_w[g]),
            .spi_sck_out     (sck_w[g]),
            .spi_mosi_out    (mosi_w[g]),
            .spi_miso_in     (miso)
        );

        // SPI memory: capture cmd+address on rising sck, shift data out on falling sck.
        always @(posedge sck_w[g] or posedge cs_n_w[g]) begin
            if (cs_n_w[g]) begin
                last_rises = bitcnt;
                bitcnt = 0;
            end else begin
                bitcnt++;
                if (bitcnt <= 32) hdr = {hdr[30:0], mosi_w[g]};
                if (bitcnt == 32) begin
                    if (exp_hdr_q[g].size() == 0) check("unexpected_frame", g, 1, 0);
                    else check("mosi_header", g, hdr, exp_hdr_q[g].pop_front());
                    a  = hdr[15:0];
                    a1 = a + 16'd1;
                    rdata = {mem[g][a], mem[g][a1]};
                end
            end
        end

        always @(negedge sck_w[g]) begin
            if (!cs_n_w[g] && bitcnt >= 32 && bitcnt < 48) miso = rdata[47 - bitcnt];
        end

        always @(negedge clk) begin
            if (!cs_n_w[g] && prev_cs) begin
                if (seen_frame) check("cs_high_gap_ge2", g, 32'(hi_cnt >= 2), 1);
                seen_frame = 1'b1;
                hi_cnt = 0;
            end
            if (cs_n_w[g]) hi_cnt++;
            prev_cs = cs_n_w[g];
            if (valid_w[g]) begin
                if (exp_instr_q[g].size() == 0) begin
                    check("unexpected_valid", g, 1, 0);
                end else begin
                    logic [15:0] e;
                    int unsigned c;
                    e = exp_instr_q[g].pop_front();
                    c = exp_cyc_q[g].pop_front();
                    check("instr", g, instr_w[g], e);
                    check("latency", g, cyc - c, 97);
                    check("sck_rises", g, last_rises, 48);
                    last_instr[g] = e;
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input bit expect_done, input bit hold_req);
        int unsigned n = 0;
        logic [23:0] ea;
        @(negedge clk);
        while (!ready_w[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 0, ready_w[0], 1);
        fetch_addr = a;
        fetch_req  = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("ready_low_after_accept", g, ready_w[g], 0);
            if (expect_done) begin
                ea = model_addr(g, a);
                exp_hdr_q[g].push_back({8'h03, ea});
                exp_instr_q[g].push_back({mem[g][ea[15:0]], mem[g][16'(ea[15:0] + 16'd1)]});
                exp_cyc_q[g].push_back(cyc);
            end
        end
        @(negedge clk);
        if (hold_req) begin
            fetch_addr = a ^ 16'h0F0E;
            repeat (40) @(negedge clk);
        end
        fetch_req = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_instr_q[0].size() != 0 || exp_instr_q[1].size() != 0 || !ready_w[0])
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 0, exp_instr_q[0].size() + exp_instr_q[1].size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 65536; i++) mem[g][i] = 8'($urandom);
            last_instr[g] = 16'h0000;
        end
        mem[0][0] = 8'hA5;
        mem[0][1] = 8'h3C;

        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_cs_n", g, cs_n_w[g], 1);
            check("reset_sck", g, sck_w[g], 0);
            check("reset_ready", g, ready_w[g], 1);
            check("reset_instr", g, instr_w[g], 16'h0000);
            check("reset_valid", g, valid_w[g], 0);
        end
        reset = 1'b0;

        issue(16'h0000, 1'b1, 1'b0);
        drain();
        check("first_instr_a53c", 0, instr_w[0], 16'hA53C);
        issue(16'h1235, 1'b1, 1'b0);
        drain();
        issue(16'h0004, 1'b1, 1'b0);
        drain();

        // Abort during the low phase of bit 30.
        issue(16'($urandom), 1'b0, 1'b0);
        repeat (61) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("flush_cs_n", g, cs_n_w[g], 1);
            check("flush_sck", g, sck_w[g], 0);
            check("flush_ready", g, ready_w[g], 1);
        end
        @(negedge clk);
        flush = 1'b0;
        repeat (120) @(negedge clk);
        for (int g = 0; g < 2; g++) check("flush_instr_held", g, instr_w[g], last_instr[g]);
        issue(16'h2468, 1'b1, 1'b0);
        drain();

        issue(16'h0100, 1'b1, 1'b1);
        issue(16'h0102, 1'b1, 1'b0);
        issue(16'h0104, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom), 1'b1, 1'b0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        drain();

        issue(16'h0200, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("midframe_reset_cs_n", g, cs_n_w[g], 1);
            check("midframe_reset_sck", g, sck_w[g], 0);
            check("midframe_reset_instr", g, instr_w[g], 16'h0000);
            last_instr[g] = 16'h0000;
        end
        @(negedge clk);
        reset = 1'b0;
        issue(16'h0300, 1'b1, 1'b0);
        drain();

        for (int g = 0; g < 2; g++) check("hdr_queue_empty", g, exp_hdr_q[g].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
